// File: rtl/mem_arbiter_2to1.sv
// mem_arbiter_2to1: round-robin 2:1 memory port arbiter with in-order response steering
module mem_arbiter_2to1 #(
    parameter type t_req_msg  = logic [77:0],
    parameter type t_resp_msg = logic [45:0],
    parameter int  p_max_inflight = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  t_req_msg   client_req_msg  [2],
    input  logic [1:0] client_req_val,
    output logic [1:0] client_req_rdy,
    output t_resp_msg  client_resp_msg [2],
    output logic [1:0] client_resp_val,
    input  logic [1:0] client_resp_rdy,
    output t_req_msg   mem_req_msg,
    output logic       mem_req_val,
    input  logic       mem_req_rdy,
    input  t_resp_msg  mem_resp_msg,
    input  logic       mem_resp_val,
    output logic       mem_resp_rdy
);
    localparam int PW = p_max_inflight > 1 ? $clog2(p_max_inflight) : 1;
    localparam int CW = $clog2(p_max_inflight + 1);

    logic          prio, lock_val, lock_id, gnt, head_id, not_full, has_resp, push, pop;
    logic          fifo [p_max_inflight];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;

    always_comb begin
        gnt             = lock_val ? lock_id : (&client_req_val) ? prio : client_req_val[1];
        not_full        = count < CW'(p_max_inflight);
        head_id         = fifo[head];
        has_resp        = rst_n && count != '0;
        mem_req_msg     = client_req_msg[gnt];
        mem_req_val     = rst_n && client_req_val[gnt] && not_full;
        client_req_rdy  = (rst_n && mem_req_rdy && not_full) ? (gnt ? 2'b10 : 2'b01) : 2'b00;
        client_resp_msg[0] = mem_resp_msg;
        client_resp_msg[1] = mem_resp_msg;
        client_resp_val = (has_resp && mem_resp_val) ? (head_id ? 2'b10 : 2'b01) : 2'b00;
        mem_resp_rdy    = has_resp && client_resp_rdy[head_id];
        push            = mem_req_val && mem_req_rdy;
        pop             = mem_resp_val && mem_resp_rdy;
    end

    // an offered but unaccepted request pins the grant so its message stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio     <= 1'b0;
            lock_val <= 1'b0;
            lock_id  <= 1'b0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            for (int i = 0; i < p_max_inflight; i++) fifo[i] <= 1'b0;
        end else begin
            if (push) begin
                fifo[tail] <= gnt;
                tail       <= tail == PW'(p_max_inflight - 1) ? '0 : tail + 1'b1;
                prio       <= ~gnt;
                lock_val   <= 1'b0;
            end else if (mem_req_val) begin
                lock_val <= 1'b1;
                lock_id  <= gnt;
            end
            if (pop) head <= head == PW'(p_max_inflight - 1) ? '0 : head + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// tb_mem_arbiter_2to1: directed self-checking bench; dut uses 4 in-flight slots, dut2 uses 2
module tb_mem_arbiter_2to1;
    typedef logic [15:0] msg_t;

    logic       clk = 1'b0, rst_n = 1'b0;
    msg_t       c_req_msg [2], c_resp_msg [2], c_resp_msg2 [2];
    logic [1:0] c_req_val, c_req_rdy, c_req_rdy2, c_resp_val, c_resp_val2, c_resp_rdy;
    msg_t       m_req_msg, m_req_msg2, m_resp_msg;
    logic       m_req_val, m_req_val2, m_req_rdy, m_resp_val, m_resp_rdy, m_resp_rdy2;
    int         n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter_2to1 #(.t_req_msg(msg_t), .t_resp_msg(msg_t)) dut (
        .clk(clk), .rst_n(rst_n),
        .client_req_msg(c_req_msg), .client_req_val(c_req_val), .client_req_rdy(c_req_rdy),
        .client_resp_msg(c_resp_msg), .client_resp_val(c_resp_val), .client_resp_rdy(c_resp_rdy),
        .mem_req_msg(m_req_msg), .mem_req_val(m_req_val), .mem_req_rdy(m_req_rdy),
        .mem_resp_msg(m_resp_msg), .mem_resp_val(m_resp_val), .mem_resp_rdy(m_resp_rdy)
    );

    mem_arbiter_2to1 #(.t_req_msg(msg_t), .t_resp_msg(msg_t), .p_max_inflight(2)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .client_req_msg(c_req_msg), .client_req_val(c_req_val), .client_req_rdy(c_req_rdy2),
        .client_resp_msg(c_resp_msg2), .client_resp_val(c_resp_val2), .client_resp_rdy(c_resp_rdy),
        .mem_req_msg(m_req_msg2), .mem_req_val(m_req_val2), .mem_req_rdy(m_req_rdy),
        .mem_resp_msg(m_resp_msg), .mem_resp_val(m_resp_val), .mem_resp_rdy(m_resp_rdy2)
    );

    task automatic chk(input string tag, input msg_t obs, input msg_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        c_req_val  = 2'b00;
        c_req_msg[0] = '0;
        c_req_msg[1] = '0;
        c_resp_rdy = 2'b00;
        m_req_rdy  = 1'b0;
        m_resp_val = 1'b0;
        m_resp_msg = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic       g, pg;
        logic [7:0] pop;
        logic [3:0] ord;
        pg = 1'b0;
        pop = '0;
        // reset holds every handshake output low even with all inputs active
        c_req_val = 2'b11; c_req_msg[0] = 16'h1111; c_req_msg[1] = 16'h2222;
        m_req_rdy = 1'b1; m_resp_val = 1'b1; m_resp_msg = 16'h3333; c_resp_rdy = 2'b11;
        #2;
        chk("rst_mem_req_val", 16'(m_req_val), 16'h0);
        chk("rst_req_rdy", 16'(c_req_rdy), 16'h0);
        chk("rst_resp_val", 16'(c_resp_val), 16'h0);
        chk("rst_mem_resp_rdy", 16'(m_resp_rdy), 16'h0);
        do_reset();
        tick();

        // single client: three reads then three responses
        m_req_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            c_req_val = 2'b01;
            c_req_msg[0] = {8'(i + 1), 8'(4 * i)};
            #1;
            chk("single_req_val", 16'(m_req_val), 16'h1);
            chk("single_req_msg", m_req_msg, {8'(i + 1), 8'(4 * i)});
            chk("single_req_rdy", 16'(c_req_rdy), 16'h1);
            tick();
        end
        c_req_val = 2'b00;
        c_resp_rdy = 2'b11;
        for (int i = 0; i < 3; i++) begin
            m_resp_val = 1'b1;
            m_resp_msg = {8'(i + 1), 8'(8'hA0 + i)};
            #1;
            chk("single_resp_val", 16'(c_resp_val), 16'h1);
            chk("single_resp_msg", c_resp_msg[0], {8'(i + 1), 8'(8'hA0 + i)});
            tick();
        end

        // contention: alternate grants, each response returned one cycle later
        do_reset();
        tick();
        m_req_rdy = 1'b1; c_resp_rdy = 2'b11; c_req_val = 2'b11;
        for (int i = 0; i < 7; i++) begin
            g = i[0];
            c_req_msg[0] = {8'(2 * i), 8'h10};
            c_req_msg[1] = {8'(2 * i + 1), 8'h20};
            if (i == 6) c_req_val = 2'b00;
            m_resp_val = i > 0;
            m_resp_msg = {pop, 8'hD0};
            #1;
            if (i < 6) begin
                chk("cont_gnt", 16'(c_req_rdy), g ? 16'h2 : 16'h1);
                chk("cont_msg", m_req_msg, {8'(2 * i + int'(g)), g ? 8'h20 : 8'h10});
            end
            if (i > 0) begin
                chk("cont_resp_val", 16'(c_resp_val), pg ? 16'h2 : 16'h1);
                chk("cont_resp_msg", c_resp_msg[pg], {pop, 8'hD0});
            end
            pop = 8'(2 * i + int'(g));
            pg = g;
            tick();
        end

        // backpressure: client 1 locked in until accepted despite client 0 priority
        do_reset();
        tick();
        c_req_msg[0] = 16'hA0A0; c_req_msg[1] = 16'hB1B1;
        c_req_val = 2'b10; m_req_rdy = 1'b0;
        #1;
        chk("lock_c0_val", 16'(m_req_val), 16'h1);
        chk("lock_c0_msg", m_req_msg, 16'hB1B1);
        chk("lock_c0_rdy", 16'(c_req_rdy), 16'h0);
        tick();
        c_req_val = 2'b11;
        for (int i = 1; i < 3; i++) begin
            #1;
            chk("lock_hold_msg", m_req_msg, 16'hB1B1);
            tick();
        end
        m_req_rdy = 1'b1;
        #1;
        chk("lock_hs_msg", m_req_msg, 16'hB1B1);
        chk("lock_hs_rdy", 16'(c_req_rdy), 16'h2);
        tick();
        c_req_val = 2'b01;
        #1;
        chk("lock_next_msg", m_req_msg, 16'hA0A0);
        chk("lock_next_rdy", 16'(c_req_rdy), 16'h1);
        tick();

        // full: two slots on dut2, pop frees space only for the following cycle
        do_reset();
        tick();
        c_req_val = 2'b11; m_req_rdy = 1'b1; c_resp_rdy = 2'b11;
        #1;
        chk("full_acc0", 16'(c_req_rdy2), 16'h1);
        tick();
        #1;
        chk("full_acc1", 16'(c_req_rdy2), 16'h2);
        tick();
        #1;
        chk("full_req_val", 16'(m_req_val2), 16'h0);
        chk("full_req_rdy", 16'(c_req_rdy2), 16'h0);
        tick();
        m_resp_val = 1'b1; m_resp_msg = 16'hC0DE;
        #1;
        chk("full_pop_req_val", 16'(m_req_val2), 16'h0);
        chk("full_pop_resp_rdy", 16'(m_resp_rdy2), 16'h1);
        chk("full_pop_resp_val", 16'(c_resp_val2), 16'h1);
        chk("full_pop_resp_msg", c_resp_msg2[0], 16'hC0DE);
        tick();
        m_resp_val = 1'b0;
        #1;
        chk("full_after_val", 16'(m_req_val2), 16'h1);
        chk("full_after_rdy", 16'(c_req_rdy2), 16'h1);
        tick();

        // steering: issue 0,1,1,0 then return in order with client 0 stalling
        do_reset();
        tick();
        ord = 4'b0110;
        m_req_rdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            c_req_val = ord[k] ? 2'b10 : 2'b01;
            #1;
            chk("steer_issue", 16'(c_req_rdy), ord[k] ? 16'h2 : 16'h1);
            tick();
        end
        c_req_val = 2'b00;
        m_resp_val = 1'b1; c_resp_rdy = 2'b10;
        for (int k = 0; k < 2; k++) begin
            m_resp_msg = 16'h5000;
            #1;
            chk("steer_stall_rdy", 16'(m_resp_rdy), 16'h0);
            chk("steer_stall_val", 16'(c_resp_val), 16'h1);
            tick();
        end
        c_resp_rdy = 2'b11;
        for (int k = 0; k < 4; k++) begin
            m_resp_msg = 16'(16'h5000 + k);
            #1;
            chk("steer_val", 16'(c_resp_val), ord[k] ? 16'h2 : 16'h1);
            chk("steer_rdy", 16'(m_resp_rdy), 16'h1);
            chk("steer_msg", c_resp_msg[ord[k]], 16'(16'h5000 + k));
            tick();
        end
        #1;
        chk("stray_resp_rdy", 16'(m_resp_rdy), 16'h0);
        chk("stray_resp_val", 16'(c_resp_val), 16'h0);
        tick();

        // asynchronous reset between edges discards prio, count and lock
        do_reset();
        tick();
        c_req_val = 2'b11; m_req_rdy = 1'b1;
        #1;
        chk("arst_pre_gnt", 16'(c_req_rdy), 16'h1);
        tick();
        m_resp_val = 1'b1; c_resp_rdy = 2'b11;
        #1;
        chk("arst_pre_resp", 16'(c_resp_val), 16'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_req_val", 16'(m_req_val), 16'h0);
        chk("arst_req_rdy", 16'(c_req_rdy), 16'h0);
        chk("arst_resp_rdy", 16'(m_resp_rdy), 16'h0);
        chk("arst_resp_val", 16'(c_resp_val), 16'h0);
        #2;
        rst_n = 1'b1;
        #1;
        chk("arst_post_gnt", 16'(c_req_rdy), 16'h1);
        chk("arst_post_resp_rdy", 16'(m_resp_rdy), 16'h0);
        chk("arst_post_resp_val", 16'(c_resp_val), 16'h0);
        tick();
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter_2to1.md
# mem_arbiter_2to1

Shares a single memory port between two in-order memory clients, such as the instruction and data ports of a core, so a one-port memory or test server can serve both. Requests pass through with zero added latency under round-robin arbitration. A small in-flight FIFO of client IDs steers each in-order memory response back to the client that issued it. It sits between the processor's two MemIntf ports and one downstream MemIntf.

## Interface
Parameters:
- t_req_msg, default `MEM_REQ(8)`: request message type; passed through unmodified.
- t_resp_msg, default `MEM_RESP(8)`: response message type; passed through unmodified.
- p_max_inflight, default 4: number of outstanding requests tracked; must be at least 1.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset; asynchronous, active-low (asserted when 0).
- client[2]  MemIntf server side  $bits(t_req_msg)/$bits(t_resp_msg)  requester ports.
  - Each carries req_msg, req_val and req_rdy in, plus resp_msg, resp_val and resp_rdy out.
  - client[0] has initial priority.
- mem  MemIntf client side  same widths  shared downstream memory port.

## Operation
- State:
  - prio (1 bit): client with priority.
  - lock_val, lock_id: hold an offered request.
  - ID FIFO: p_max_inflight entries of 1 bit, with head/tail pointers and count, where count ranges over 0..p_max_inflight.
- Grant selection (combinational):
  - If lock_val is set, gnt = lock_id.
  - Else, if both clients are valid, gnt = prio.
  - Else, gnt = whichever client is valid.
  - If neither is valid, mem.req_val = 0.
- Request path:
  - mem.req_val = client[gnt].req_val && (count < p_max_inflight).
  - mem.req_msg = client[gnt].req_msg.
  - client[gnt].req_rdy = mem.req_rdy && (count < p_max_inflight).
  - The non-granted client sees req_rdy = 0.
- Lock: set lock_val = 1 and lock_id = gnt when mem.req_val && !mem.req_rdy. Clear it on the handshake. This keeps the offered message stable until it is accepted, as val/rdy requires.
- On each request handshake (mem.req_val && mem.req_rdy):
  - Push gnt into the FIFO.
  - Set prio = ~gnt.
  - Clear the lock.
- Response path:
  - When count > 0, let h = FIFO head. Then client[h].resp_val = mem.resp_val, client[h].resp_msg = mem.resp_msg, and mem.resp_rdy = client[h].resp_rdy.
  - When count == 0, mem.resp_rdy = 0 and both client resp_val = 0.
- On each response handshake, pop the FIFO head.
- A response arriving with count == 0 is a protocol error. It is never accepted; the bench flags it.
- The arbiter never modifies message contents, including the opaque field.

## Timing
- Request and response paths are purely combinational; there is zero added latency.
- FIFO, prio and lock update on posedge clk.
- Reset (rst = 0, asynchronous): prio = 0, lock_val = 0, count = 0, head = tail = 0.
- Outputs during reset:
  - mem.req_val = 0, mem.resp_rdy = 0.
  - All client req_rdy = 0 and resp_val = 0.
- Full (count == p_max_inflight):
  - No new grant; mem.req_val = 0.
  - A pop in the same cycle frees space for the next cycle only. The full check uses the registered count, not bypassed.
  - The lock stays held; lock_id is preserved.
- Simultaneous push and pop: count is unchanged; head and tail both advance.
- Pointers wrap modulo p_max_inflight, which need not be a power of 2.
- Both clients valid every cycle with mem.req_rdy = 1: grants alternate 0,1,0,1,… starting at 0 after reset.
- A client that drops req_val while locked violates the protocol. The lock then releases only on a handshake, so the bench must not do this.
- Reset mid-operation: the FIFO and lock are discarded. Any in-flight responses are dropped by the environment, which is reset too.

## Test plan
- Single client: client[0] sends 3 reads at addr 0x0, 0x4, 0x8 with the memory delay at 0. The memory sees the same 3 messages in order. client[0] gets 3 responses and client[1] gets none.
- Contention: both clients hold req_val = 1 for 6 cycles with mem.req_rdy = 1. Grant order is 0,1,0,1,0,1. Responses route back with matching opaque fields.
- Backpressure lock:
  - Setup: client[1] alone offers at cycle 0 with mem.req_rdy = 0 for 3 cycles. client[0] becomes valid at cycle 1.
  - Expected: client[1]'s msg is held stable until the handshake at cycle 3. client[0] is granted at cycle 4.
- Full: p_max_inflight = 2 with mem.resp_val held 0.
  - After 2 accepts, mem.req_val = 0 and both client req_rdy = 0.
  - After one response is popped, the next request is accepted the following cycle.
- Response steering:
  - Setup: requests issued in order 0,1,1,0, then responses returned with client[0].resp_rdy = 0 for 2 cycles.
  - Expected: mem.resp_rdy = 0 while the head ID is 0. Responses are delivered in order 0,1,1,0.
- Async reset: assert rst = 0 mid-burst between clock edges. All outputs are deasserted immediately, count = 0 and prio = 0. Normal operation resumes after rst = 1.
